ops_arbiter: RTL and testbench

Two-requester front end for the posit `ops` datapath. It arbitrates round-robin between two independent request ports and issues at most one operation per cycle into the fixed-latency `ops` pipeline. It tracks in-flight operations with a tag shift register and steers each `ops_out_meta_t` result back to the requester that issued it. Per-port response FIFOs with credit counting guarantee that a result never arrives with nowhere to go, because the datapath cannot stall.

---
 rtl/ops_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ops_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ops_arbiter.sv
`default_nettype none
// ============================================================================
// ops_arbiter : two-port round-robin front end for the fixed-latency ops
//               pipeline, with result steering and credited response FIFOs.
// Revision    : 1.0
// ============================================================================
module ops_arbiter #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2,
  parameter int OP_W    = 4,
  parameter int FIR_W   = 32,
  parameter int RES_W   = 40
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0][OP_W-1:0]  req_op_i,
  input  logic [1:0][FIR_W-1:0] req_fir1_i,
  input  logic [1:0][FIR_W-1:0] req_fir2_i,
  input  logic [1:0][FIR_W-1:0] req_fir3_i,
  output logic                  issue_valid_o,
  output logic [OP_W-1:0]       op_o,
  output logic [FIR_W-1:0]      fir1_o,
  output logic [FIR_W-1:0]      fir2_o,
  output logic [FIR_W-1:0]      fir3_o,
  input  logic [RES_W-1:0]      ops_result_i,
  output logic [1:0]            resp_valid_o,
  input  logic [1:0]            resp_ready_i,
  output logic [1:0][RES_W-1:0] resp_data_o
);

  localparam int              c_CW        = $clog2(DEPTH + 1);
  localparam int              c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);
  localparam logic [c_AW-1:0] c_PTR_LAST  = c_AW'(DEPTH - 1);

  logic [1:0]         w_elig;
  logic [1:0]         w_grant;
  logic [1:0]         w_has_credit;
  logic [1:0]         w_push;
  logic [1:0]         w_pop;
  logic               w_win;
  logic [LATENCY-1:0] w_tag_v_nxt;
  logic [LATENCY-1:0] w_tag_p_nxt;

  logic               r_prio;
  logic               r_issue_valid;
  logic               r_issue_port;
  logic [OP_W-1:0]    r_op;
  logic [FIR_W-1:0]   r_fir1;
  logic [FIR_W-1:0]   r_fir2;
  logic [FIR_W-1:0]   r_fir3;
  logic [LATENCY-1:0] r_tag_v;
  logic [LATENCY-1:0] r_tag_p;

  // Grants are gated by reset so nothing is accepted while rst_i is low.
  assign w_elig = req_valid_i & w_has_credit & {2{rst_i}};

  always_comb begin
    w_grant = w_elig;
    if (w_elig == 2'b11) begin
      w_grant = r_prio ? 2'b10 : 2'b01;
    end
  end

  assign w_win       = w_grant[1];
  assign req_ready_o = w_grant;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_prio        <= 1'b0;
      r_issue_valid <= 1'b0;
      r_issue_port  <= 1'b0;
      r_op          <= '0;
      r_fir1        <= '0;
      r_fir2        <= '0;
      r_fir3        <= '0;
    end else begin
      r_issue_valid <= |w_grant;
      if (|w_grant) begin
        r_prio       <= ~w_win;
        r_issue_port <= w_win;
        r_op         <= req_op_i[w_win];
        r_fir1       <= req_fir1_i[w_win];
        r_fir2       <= req_fir2_i[w_win];
        r_fir3       <= req_fir3_i[w_win];
      end
    end
  end

  assign issue_valid_o = r_issue_valid;
  assign op_o          = r_op;
  assign fir1_o        = r_fir1;
  assign fir2_o        = r_fir2;
  assign fir3_o        = r_fir3;

  // Tag stage LATENCY-1 lines up with the result currently on ops_result_i.
  generate
    if (LATENCY == 1) begin : g_tag_single
      assign w_tag_v_nxt = r_issue_valid;
      assign w_tag_p_nxt = r_issue_port;
    end else begin : g_tag_shift
      assign w_tag_v_nxt = {r_tag_v[LATENCY-2:0], r_issue_valid};
      assign w_tag_p_nxt = {r_tag_p[LATENCY-2:0], r_issue_port};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_tag_v <= '0;
      r_tag_p <= '0;
    end else begin
      r_tag_v <= w_tag_v_nxt;
      r_tag_p <= w_tag_p_nxt;
    end
  end

  assign w_push[0] = r_tag_v[LATENCY-1] & ~r_tag_p[LATENCY-1];
  assign w_push[1] = r_tag_v[LATENCY-1] &  r_tag_p[LATENCY-1];

  generate
    for (genvar k = 0; k < 2; k++) begin : g_port
      logic [RES_W-1:0] r_mem [DEPTH];
      logic [c_AW-1:0]  r_wp;
      logic [c_AW-1:0]  r_rp;
      logic [c_CW-1:0]  r_cnt;
      logic [c_CW-1:0]  r_credit;

      assign w_has_credit[k] = (r_credit != '0);
      assign resp_valid_o[k] = (r_cnt != '0);
      assign w_pop[k]        = (r_cnt != '0) & resp_ready_i[k];
      assign resp_data_o[k]  = r_mem[r_rp];

      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
          end
          r_wp     <= '0;
          r_rp     <= '0;
          r_cnt    <= '0;
          r_credit <= c_DEPTH;
        end else begin
          if (w_push[k]) begin
            r_mem[r_wp] <= ops_result_i;
            r_wp        <= (r_wp == c_PTR_LAST) ? '0 : r_wp + c_PTR_ONE;
          end
          if (w_pop[k]) begin
            r_rp <= (r_rp == c_PTR_LAST) ? '0 : r_rp + c_PTR_ONE;
          end
          if (w_push[k] && !w_pop[k]) begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end else if (!w_push[k] && w_pop[k]) begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
          // A credit freed by a pop only becomes grantable next cycle.
          if (w_grant[k] && !w_pop[k]) begin
            r_credit <= r_credit - c_CNT_ONE;
          end else if (!w_grant[k] && w_pop[k]) begin
            r_credit <= r_credit + c_CNT_ONE;
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ops_arbiter.sv
`default_nettype none
// tb_ops_arbiter : three ops_arbiter configurations driven with shared stimulus,
// checked against directed vectors and a queue-based reference model.
module tb_ops_arbiter;

  localparam int OP_W  = 3;
  localparam int FIR_W = 8;
  localparam int RES_W = 16;
  localparam int NI    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [1:0]            req_valid;
  logic [1:0]            resp_ready;
  logic [1:0][OP_W-1:0]  req_op;
  logic [1:0][FIR_W-1:0] req_f1, req_f2, req_f3;

  logic [1:0]            rdy  [NI];
  logic                  iv   [NI];
  logic [OP_W-1:0]       opo  [NI];
  logic [FIR_W-1:0]      f1o  [NI];
  logic [FIR_W-1:0]      f2o  [NI];
  logic [FIR_W-1:0]      f3o  [NI];
  logic [RES_W-1:0]      ores [NI];
  logic [1:0]            rv   [NI];
  logic [1:0][RES_W-1:0] rdat [NI];

  function automatic int lat_of(int i);
    return (i == 1) ? 1 : 2;
  endfunction

  function automatic int dep_of(int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [RES_W-1:0] fres(logic [OP_W-1:0] op, logic [FIR_W-1:0] a,
                                            logic [FIR_W-1:0] b, logic [FIR_W-1:0] c);
    return {a ^ c, b + FIR_W'(op)};
  endfunction

  ops_arbiter #(.LATENCY(2), .DEPTH(2), .OP_W(OP_W), .FIR_W(FIR_W), .RES_W(RES_W)) u_a (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
    .req_op_i(req_op), .req_fir1_i(req_f1), .req_fir2_i(req_f2), .req_fir3_i(req_f3),
    .issue_valid_o(iv[0]), .op_o(opo[0]), .fir1_o(f1o[0]), .fir2_o(f2o[0]), .fir3_o(f3o[0]),
    .ops_result_i(ores[0]), .resp_valid_o(rv[0]), .resp_ready_i(resp_ready),
    .resp_data_o(rdat[0]));

  ops_arbiter #(.LATENCY(1), .DEPTH(1), .OP_W(OP_W), .FIR_W(FIR_W), .RES_W(RES_W)) u_b (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
    .req_op_i(req_op), .req_fir1_i(req_f1), .req_fir2_i(req_f2), .req_fir3_i(req_f3),
    .issue_valid_o(iv[1]), .op_o(opo[1]), .fir1_o(f1o[1]), .fir2_o(f2o[1]), .fir3_o(f3o[1]),
    .ops_result_i(ores[1]), .resp_valid_o(rv[1]), .resp_ready_i(resp_ready),
    .resp_data_o(rdat[1]));

  ops_arbiter #(.LATENCY(2), .DEPTH(8), .OP_W(OP_W), .FIR_W(FIR_W), .RES_W(RES_W)) u_c (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[2]),
    .req_op_i(req_op), .req_fir1_i(req_f1), .req_fir2_i(req_f2), .req_fir3_i(req_f3),
    .issue_valid_o(iv[2]), .op_o(opo[2]), .fir1_o(f1o[2]), .fir2_o(f2o[2]), .fir3_o(f3o[2]),
    .ops_result_i(ores[2]), .resp_valid_o(rv[2]), .resp_ready_i(resp_ready),
    .resp_data_o(rdat[2]));

  // Stand-in for the ops datapath: always computes, never stalls.
  logic [RES_W-1:0] st1 [NI];
  logic [RES_W-1:0] st2 [NI];
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      st1[i] <= fres(opo[i], f1o[i], f2o[i], f3o[i]);
      st2[i] <= st1[i];
    end
  end
  assign ores[0] = st2[0];
  assign ores[1] = st1[1];
  assign ores[2] = st2[2];

  // Reference model: credits, pointer, expected issue register, in-flight list, FIFO queues.
  typedef struct {
    int               port;
    int               due;
    logic [RES_W-1:0] res;
  } infl_t;

  infl_t            infl    [NI][$];
  logic [RES_W-1:0] fq      [NI*2][$];
  logic             m_clean [NI*2];
  int               m_credit[NI][2];
  logic             m_prio  [NI];
  logic             m_iv    [NI];
  logic [OP_W-1:0]  m_op    [NI];
  logic [FIR_W-1:0] m_f1    [NI];
  logic [FIR_W-1:0] m_f2    [NI];
  logic [FIR_W-1:0] m_f3    [NI];
  int               edge_n;
  int               checks;
  int               errors;

  task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d t=%0t got=%0h exp=%0h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic model_reset(int i);
    infl[i].delete();
    for (int k = 0; k < 2; k++) begin
      fq[2*i+k].delete();
      m_clean[2*i+k]  = 1'b1;
      m_credit[i][k]  = dep_of(i);
    end
    m_prio[i] = 1'b0;
    m_iv[i]   = 1'b0;
    m_op[i]   = '0;
    m_f1[i]   = '0;
    m_f2[i]   = '0;
    m_f3[i]   = '0;
  endtask

  // Compare every output against the model, then advance the model across the coming edge.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      logic [1:0] g;
      int         w;
      int         q;
      infl_t      e;
      g = 2'b00;
      w = -1;
      if (rst_n) begin
        if (req_valid[0] && m_credit[i][0] > 0 && req_valid[1] && m_credit[i][1] > 0)
          w = m_prio[i] ? 1 : 0;
        else if (req_valid[0] && m_credit[i][0] > 0)
          w = 0;
        else if (req_valid[1] && m_credit[i][1] > 0)
          w = 1;
      end
      if (w >= 0) g[w] = 1'b1;
      chk("ready", i, 32'(rdy[i]), 32'(g));
      chk("issue_valid", i, 32'(iv[i]), 32'(m_iv[i]));
      chk("op", i, 32'(opo[i]), 32'(m_op[i]));
      chk("fir1", i, 32'(f1o[i]), 32'(m_f1[i]));
      chk("fir2", i, 32'(f2o[i]), 32'(m_f2[i]));
      chk("fir3", i, 32'(f3o[i]), 32'(m_f3[i]));
      for (int k = 0; k < 2; k++) begin
        q = 2*i + k;
        chk("resp_valid", i, 32'(rv[i][k]), 32'(fq[q].size() != 0));
        if (fq[q].size() != 0)
          chk("resp_data", i, 32'(rdat[i][k]), 32'(fq[q][0]));
        else if (m_clean[q])
          chk("resp_data_clear", i, 32'(rdat[i][k]), 32'h0);
      end
      if (!rst_n) begin
        model_reset(i);
      end else begin
        for (int k = 0; k < 2; k++) begin
          q = 2*i + k;
          if (fq[q].size() != 0 && resp_ready[k]) begin
            void'(fq[q].pop_front());
            m_credit[i][k]++;
          end
        end
        while (infl[i].size() > 0 && infl[i][0].due == edge_n) begin
          e = infl[i].pop_front();
          fq[2*i+e.port].push_back(e.res);
          m_clean[2*i+e.port] = 1'b0;
        end
        if (w >= 0) begin
          m_credit[i][w]--;
          m_prio[i] = (w == 0);
          m_iv[i]   = 1'b1;
          m_op[i]   = req_op[w];
          m_f1[i]   = req_f1[w];
          m_f2[i]   = req_f2[w];
          m_f3[i]   = req_f3[w];
          e.port    = w;
          e.due     = edge_n + lat_of(i) + 1;
          e.res     = fres(req_op[w], req_f1[w], req_f2[w], req_f3[w]);
          infl[i].push_back(e);
        end else begin
          m_iv[i] = 1'b0;
        end
      end
    end
    edge_n++;
  endtask

  task automatic drive(logic n, logic [1:0] v, logic [1:0] rr);
    rst_n      = n;
    req_valid  = v;
    resp_ready = rr;
    for (int k = 0; k < 2; k++) begin
      req_op[k] = OP_W'($urandom);
      req_f1[k] = FIR_W'($urandom);
      req_f2[k] = FIR_W'($urandom);
      req_f3[k] = FIR_W'($urandom);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] v;
    logic [1:0] rr;
    logic [1:0] rdy;
    logic       iv;
    logic [1:0] rv;
  } vec_t;

  vec_t             tbl [10];
  logic [RES_W-1:0] r1, r2;

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    for (int i = 0; i < NI; i++) model_reset(i);

    // Instance a (LATENCY 2, DEPTH 2): single request, then credit exhaustion on port 0.
    tbl[0] = '{v:2'b01, rr:2'b00, rdy:2'b01, iv:1'b0, rv:2'b00};
    tbl[1] = '{v:2'b01, rr:2'b00, rdy:2'b01, iv:1'b1, rv:2'b00};
    tbl[2] = '{v:2'b01, rr:2'b00, rdy:2'b00, iv:1'b1, rv:2'b00};
    tbl[3] = '{v:2'b01, rr:2'b00, rdy:2'b00, iv:1'b0, rv:2'b00};
    tbl[4] = '{v:2'b01, rr:2'b00, rdy:2'b00, iv:1'b0, rv:2'b01};
    tbl[5] = '{v:2'b01, rr:2'b00, rdy:2'b00, iv:1'b0, rv:2'b01};
    tbl[6] = '{v:2'b01, rr:2'b01, rdy:2'b00, iv:1'b0, rv:2'b01};
    tbl[7] = '{v:2'b01, rr:2'b00, rdy:2'b01, iv:1'b0, rv:2'b01};
    tbl[8] = '{v:2'b01, rr:2'b00, rdy:2'b00, iv:1'b1, rv:2'b01};
    tbl[9] = '{v:2'b00, rr:2'b00, rdy:2'b00, iv:1'b0, rv:2'b01};

    drive(1'b0, 2'b00, 2'b00);
    adv();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 2'b11, 2'b11);
      sample();
      for (int i = 0; i < NI; i++) begin
        chk("rst_ready", i, 32'(rdy[i]), 32'h0);
        chk("rst_resp_valid", i, 32'(rv[i]), 32'h0);
      end
      adv();
    end

    for (int r = 0; r < 10; r++) begin
      drive(1'b1, tbl[r].v, tbl[r].rr);
      sample();
      chk("tbl_ready", r, 32'(rdy[0]), 32'(tbl[r].rdy));
      chk("tbl_issue_valid", r, 32'(iv[0]), 32'(tbl[r].iv));
      chk("tbl_resp_valid", r, 32'(rv[0]), 32'(tbl[r].rv));
      adv();
    end

    repeat (8) begin drive(1'b1, 2'b00, 2'b11); sample(); adv(); end

    // Port 1 on instance a: head R1 popped in the same cycle R2 is written.
    drive(1'b1, 2'b10, 2'b00);
    r1 = fres(req_op[1], req_f1[1], req_f2[1], req_f3[1]);
    sample(); chk("pp_grant0", 0, 32'(rdy[0]), 32'h2); adv();
    drive(1'b1, 2'b10, 2'b00);
    r2 = fres(req_op[1], req_f1[1], req_f2[1], req_f3[1]);
    sample(); chk("pp_grant1", 0, 32'(rdy[0]), 32'h2); adv();
    repeat (2) begin drive(1'b1, 2'b00, 2'b00); sample(); adv(); end
    drive(1'b1, 2'b00, 2'b10);
    sample();
    chk("pp_rv_c4", 0, 32'(rv[0]), 32'h2);
    chk("pp_head_r1", 0, 32'(rdat[0][1]), 32'(r1));
    adv();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 2'b00, 2'b00);
      sample();
      chk("pp_rv_after", 0, 32'(rv[0]), 32'h2);
      chk("pp_head_r2", 0, 32'(rdat[0][1]), 32'(r2));
      adv();
    end

    repeat (6) begin drive(1'b1, 2'b00, 2'b11); sample(); adv(); end

    // Reset with two operations in flight; stale results must be dropped.
    repeat (2) begin drive(1'b1, 2'b11, 2'b00); sample(); adv(); end
    drive(1'b0, 2'b00, 2'b00); sample(); adv();
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, 2'b00, 2'b11);
      sample();
      for (int i = 0; i < NI; i++) chk("post_rst_rv", i, 32'(rv[i]), 32'h0);
      adv();
    end

    // Contention after reset: instance c (DEPTH 8) alternates starting at port 0.
    for (int p = 0; p < 6; p++) begin
      drive(1'b1, 2'b11, 2'b11);
      sample();
      chk("contend_c", p, 32'(rdy[2]), (p % 2 == 1) ? 32'h2 : 32'h1);
      if (p == 0) begin
        for (int i = 0; i < NI; i++) chk("first_contended", i, 32'(rdy[i]), 32'h1);
      end
      adv();
    end
    repeat (10) begin drive(1'b1, 2'b00, 2'b11); sample(); adv(); end

    // Randomized run, including occasional mid-flight resets.
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 299) != 0, 2'($urandom),
            ($urandom_range(0, 3) != 0) ? 2'($urandom) : 2'b00);
      sample();
      adv();
    end

    repeat (12) begin drive(1'b1, 2'b00, 2'b11); sample(); adv(); end
    drive(1'b1, 2'b00, 2'b11);
    sample();
    for (int i = 0; i < NI; i++) chk("drained", i, 32'(rv[i]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
